// File: rtl/led_pattern_scheduler_pkg.sv
// Shared encodings and the LED pattern decode for the LED pattern scheduler.
package led_sched_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BINARY = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    function automatic logic [3:0] led_decode(input mode_t mode, input logic [3:0] step);
        logic [3:0] pattern;
        pattern = 4'b0000;
        case (mode)
            MODE_OFF:    pattern = 4'b0000;
            MODE_BLINK:  pattern = {4{step[0]}};
            MODE_CHASE:  pattern = 4'b0001 << step[1:0];
            MODE_BINARY: pattern = step;
            default:     pattern = 4'b0000;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// Prescaler: counts while running and pulses tick when the count reaches the divider.
module led_tick_prescaler #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] div_cnt;

    assign tick = run && (div_cnt == div);

    // The count only moves in RUN, so a pause resumes exactly where it stopped.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (clear) begin
            div_cnt <= '0;
        end else if (run) begin
            if (div_cnt == div) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_pattern_scheduler.sv
// LED pattern scheduler: run/pause FSM, single-entry config slot and pattern stepping.
module led_pattern_scheduler
    import led_sched_pkg::*;
#(
    parameter int DIV_W        = 24,
    parameter int DEFAULT_DIV  = 262143,
    parameter int DEFAULT_MODE = 0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             CfgValid,
    output logic             CfgReady,
    input  logic [1:0]       CfgMode,
    input  logic [DIV_W-1:0] CfgDivider,
    output logic             Tick,
    output logic [3:0]       Step,
    output logic             Running,
    output logic [3:0]       LED
);

    localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(DEFAULT_DIV);
    localparam mode_t            DEF_MODE = mode_t'(2'(DEFAULT_MODE));

    state_t           state;
    mode_t            mode_reg;
    logic [DIV_W-1:0] div_reg;
    logic [3:0]       step_reg;
    logic             pending_full;
    mode_t            pend_mode;
    logic [DIV_W-1:0] pend_div;
    logic             tick;
    logic             accept;
    logic             apply;

    // A pending config waits for a tick while running, otherwise it lands one cycle after acceptance.
    assign accept = CfgValid && !pending_full;
    assign apply  = pending_full && ((state != RUN) || tick);

    led_tick_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk   (Clock),
        .reset (Reset),
        .run   (state == RUN),
        .clear (apply),
        .div   (div_reg),
        .tick  (tick)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= IDLE;
            mode_reg     <= DEF_MODE;
            div_reg      <= DEF_DIV;
            step_reg     <= 4'd0;
            pending_full <= 1'b0;
            pend_mode    <= MODE_OFF;
            pend_div     <= '0;
        end else begin
            if (apply) begin
                mode_reg     <= pend_mode;
                div_reg      <= pend_div;
                step_reg     <= 4'd0;
                pending_full <= 1'b0;
            end else if (tick) begin
                step_reg <= step_reg + 4'd1;
            end

            if (accept) begin
                pending_full <= 1'b1;
                pend_mode    <= mode_t'(CfgMode);
                pend_div     <= CfgDivider;
            end

            if (apply && (pend_mode == MODE_OFF)) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE:    if (Enable && (mode_reg != MODE_OFF)) state <= RUN;
                    RUN:     if (!Enable) state <= PAUSE;
                    PAUSE:   if (Enable) state <= RUN;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign Tick     = tick;
    assign Step     = step_reg;
    assign Running  = (state == RUN);
    assign CfgReady = !pending_full;
    assign LED      = led_decode(mode_reg, step_reg);

endmodule
